// File: rtl/usb_fs_transmitter_if.sv
// Byte-stream handshake and line-side signals between the device controller
// (master) and the full-speed transmitter (slave).
interface usb_fs_transmitter_if;
  logic       start;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       usb_dp;
  logic       usb_dn;
  logic       output_enable;
  logic       busy;
  logic       done;
  logic       underrun;

  modport master (
    output start, data_in, data_valid, data_last,
    input  data_ready, usb_dp, usb_dn, output_enable, busy, done, underrun
  );

  modport slave (
    input  start, data_in, data_valid, data_last,
    output data_ready, usb_dp, usb_dn, output_enable, busy, done, underrun
  );
endinterface

// File: rtl/usb_fs_transmitter.sv
// USB full-speed packet transmitter: SYNC, LSB-first NRZI data with bit
// stuffing, SE0/SE0/J end-of-packet, then the pads are released.
module usb_fs_transmitter #(
  parameter int CLOCKS_PER_BIT = 4
) (
  input  logic                 clock48,
  input  logic                 reset,
  usb_fs_transmitter_if.slave  tx
);
  localparam int TW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    sent_q, sent_d;
  logic [7:0]    shift_q, shift_d;
  logic          last_q, last_d;
  logic          level_q, level_d;
  logic [2:0]    ones_q, ones_d;
  logic          abort_q, abort_d;
  logic          done_q, done_d;
  logic          underrun_q, underrun_d;

  logic          bit_end;
  logic          ready_c;
  logic          emit;
  logic          eop_pend;
  logic          starve;
  logic [7:0]    byte_v;
  logic [3:0]    sent_v;

  assign bit_end = (timer_q == TW'(CLOCKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    bit_cnt_d  = bit_cnt_q;
    sent_d     = sent_q;
    shift_d    = shift_q;
    last_d     = last_q;
    level_d    = level_q;
    ones_d     = ones_q;
    abort_d    = abort_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    ready_c    = 1'b0;
    emit       = 1'b0;
    eop_pend   = 1'b0;
    starve     = 1'b0;
    byte_v     = shift_q;
    sent_v     = sent_q;

    if (state_q != IDLE) begin
      timer_d = bit_end ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        ready_c = tx.start & tx.data_valid;
        if (tx.start && tx.data_valid) begin
          state_d   = SYNC;
          shift_d   = tx.data_in;
          last_d    = tx.data_last;
          sent_d    = '0;
          bit_cnt_d = '0;
          level_d   = 1'b0;
          ones_d    = 3'd1;     // the closing K of SYNC counts as a one
          abort_d   = 1'b0;
        end
      end
      SYNC: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            emit = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q != 3'd6) level_d = ~level_q;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          // Byte boundary: the next byte may be loaded before a pending stuff bit.
          if (sent_q == 4'd8) begin
            if (last_q) begin
              eop_pend = 1'b1;
            end else begin
              ready_c = 1'b1;
              if (tx.data_valid) begin
                byte_v = tx.data_in;
                sent_v = '0;
                last_d = tx.data_last;
              end else begin
                starve = 1'b1;
              end
            end
          end
          if (starve) begin
            state_d   = EOP_SE0;
            bit_cnt_d = '0;
            abort_d   = 1'b1;
          end else if (ones_q == 3'd6) begin
            state_d = STUFF;
            level_d = ~level_q;
            ones_d  = '0;
            shift_d = byte_v;
            sent_d  = sent_v;
          end else if (eop_pend) begin
            state_d   = EOP_SE0;
            bit_cnt_d = '0;
          end else begin
            emit = 1'b1;
          end
        end
      end
      STUFF: begin
        if (bit_end) begin
          if (last_q && sent_q == 4'd8) begin
            state_d   = EOP_SE0;
            bit_cnt_d = '0;
          end else begin
            emit = 1'b1;
          end
        end
      end
      EOP_SE0: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd1) begin
            state_d = EOP_J;
            level_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      EOP_J: begin
        if (bit_end) begin
          state_d    = IDLE;
          done_d     = ~abort_q;
          underrun_d = abort_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // NRZI: a zero toggles the line, a one holds it.
    if (emit) begin
      state_d = DATA;
      level_d = byte_v[0] ? level_q : ~level_q;
      ones_d  = byte_v[0] ? ones_q + 3'd1 : 3'd0;
      shift_d = {1'b0, byte_v[7:1]};
      sent_d  = sent_v + 4'd1;
    end
  end

  always_ff @(posedge clock48) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      sent_q     <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      level_q    <= 1'b1;
      ones_q     <= '0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      sent_q     <= sent_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      level_q    <= level_d;
      ones_q     <= ones_d;
      abort_q    <= abort_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign tx.data_ready    = ready_c & ~reset;
  assign tx.output_enable = (state_q != IDLE);
  assign tx.busy          = (state_q != IDLE);
  assign tx.usb_dp        = (state_q == EOP_SE0) ? 1'b0 : level_q;
  assign tx.usb_dn        = (state_q == EOP_SE0) ? 1'b0 : ~level_q;
  assign tx.done          = done_q;
  assign tx.underrun      = underrun_q;
endmodule
